addsub_pipe: RTL and testbench
==============================

# addsub_pipe

- Parametrised, pipelined two's-complement add/subtract unit.
- Splits a WIDTH-bit operation into SLICE-bit ripple slices, one slice per pipeline stage, with the carry registered between stages.
- Produces sum/difference plus carry, signed-overflow and zero flags behind a valid/ready handshake.
- Next-generation arithmetic core of the ALU datapath; replaces fixed 4-bit ripple adders where wider operands and higher clock rates are required.

## Interface
- WIDTH, 16, operand/result width in bits; must be ≥2 and a multiple of SLICE.
- SLICE, 4, bits resolved per pipeline stage; STAGES = WIDTH/SLICE.
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- in_valid  in  1  operand beat present.
- in_ready  out  1  unit accepts a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- sub  in  1  0: a+b, 1: a−b.
- out_valid  out  1  result beat present.
- out_ready  in  1  downstream accepts result.
- q  out  WIDTH  result.
- cout  out  1  carry out of MSB (for sub: 1 = no borrow, i.e. a ≥ b unsigned).
- ovf  out  1  signed overflow of the unsaturated result.
- zero  out  1  q == 0.

## Operation
- Subtract implemented as a + ~b + 1: slice 0 carry-in = sub; b inverted at entry when sub=1.
- Stage k (0..STAGES−1) ripples bits [k·SLICE +: SLICE] using the carry registered by stage k−1.
- Unresolved operand slices are carried forward (skew registers).
- Resolved result slices are carried forward (deskew registers), so q emerges aligned.
- Per-stage valid bit travels with the data.
- Last stage computes cout = carry out of bit WIDTH−1; ovf = carry into MSB XOR carry out of MSB.
- zero is computed on the final q, after any saturation.
- Global stall: stall = out_valid & ~out_ready. When stall=1, every stage register holds.
- in_ready = ~stall (combinational). A beat is accepted iff in_valid & in_ready.
- Bubbles are not compacted: an empty stage still advances only when not stalled.
- Results leave strictly in acceptance order; no loss, no duplication.
- Result fields are held stable while out_valid=1 and out_ready=0.

## Timing
- Latency: a beat accepted at edge n presents out_valid=1 after edge n+STAGES−1, i.e. STAGES register stages. Latency is 4 for the defaults; SLICE=WIDTH gives latency 1.
- Throughput: one beat per cycle while out_ready=1.
- Reset (rst_n low, asynchronous): all valid bits 0, out_valid=0, q=0, cout=0, ovf=0, zero=0. in_ready=1 once out_valid=0.
- Reset mid-operation: all in-flight beats are discarded. The first result after reset release belongs to the first beat accepted after release.
- Simultaneous output handshake and input acceptance in the same cycle is legal and required at full rate.
- in_valid low: bubbles propagate and out_valid falls after them.

## Configuration
- ADDSUB_SAT_EN defined: on ovf=1, q saturates to 0x7F…F (positive overflow, MSB carry-in=1) or 0x80…0 (negative overflow). ovf and cout still report the raw event. zero is never 1 for a saturated result.
- ADDSUB_SAT_EN undefined: q wraps modulo 2^WIDTH; no saturation logic present.

## Test plan
- WIDTH=16, SLICE=4, add 0x7FFF+0x0001 → 4 cycles later q=0x8000, ovf=1, cout=0, zero=0 (with ADDSUB_SAT_EN: q=0x7FFF).
- Add 0xFFFF+0x0001 → q=0x0000, cout=1, ovf=0, zero=1.
- Sub 0x0005−0x0007 → q=0xFFFE, cout=0, ovf=0; sub 0x8000−0x0001 → q=0x7FFF, ovf=1 (with ADDSUB_SAT_EN: q=0x8000).
- 16 back-to-back random beats with out_ready pattern 1,0,0,1,1,0… → all 16 results in order, matching the reference model. in_ready=0 exactly in stall cycles; q stable while stalled.
- Assert rst_n low for 1 cycle with 3 beats in flight → out_valid=0 immediately. After release, the next out_valid carries only post-reset data.
- SLICE=16 build: add 0x1234+0x4321 → q=0x5555 one cycle after acceptance.

Source files
------------

// File: rtl/addsub_pipe.sv
// addsub_pipe: pipelined two's-complement add/subtract, one SLICE-bit ripple slice per stage.
// Optional ADDSUB_SAT_EN: saturate q on signed overflow instead of wrapping modulo 2^WIDTH.
module addsub_pipe #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int STAGES = WIDTH / SLICE;
  localparam int L      = STAGES - 1;

  logic stall, adv;

  // Stage registers; index k holds the state captured by stage k.
  logic             vld_p [STAGES];
  logic             cy_p  [STAGES];
  logic [WIDTH-1:0] a_p   [STAGES];
  logic [WIDTH-1:0] b_p   [STAGES];
  logic [WIDTH-1:0] r_p   [STAGES];

  // Inputs seen by each stage and the combinational result it produces.
  logic             v_src [STAGES];
  logic             c_src [STAGES];
  logic [WIDTH-1:0] a_src [STAGES];
  logic [WIDTH-1:0] b_src [STAGES];
  logic [WIDTH-1:0] r_src [STAGES];
  logic [SLICE:0]   s_c   [STAGES];
  logic [WIDTH-1:0] r_o   [STAGES];

  logic             c_msb, ov;
  logic [WIDTH-1:0] q_n;

  function automatic logic [SLICE:0] slice_add(input logic [SLICE-1:0] x,
                                               input logic [SLICE-1:0] y,
                                               input logic             ci);
    return {1'b0, x} + {1'b0, y} + {{SLICE{1'b0}}, ci};
  endfunction

`ifdef ADDSUB_SAT_EN
  function automatic logic [WIDTH-1:0] sat_q(input logic [WIDTH-1:0] raw,
                                             input logic             ovf_raw,
                                             input logic             cin_msb);
    if (!ovf_raw) return raw;
    return cin_msb ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
  endfunction
`endif

  assign stall     = out_valid & ~out_ready;
  assign adv       = ~stall;
  assign in_ready  = adv;
  assign out_valid = vld_p[L];

  always_comb begin
    v_src[0] = in_valid;
    c_src[0] = sub;
    a_src[0] = a;
    b_src[0] = b ^ {WIDTH{sub}};
    r_src[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      v_src[k] = vld_p[k-1];
      c_src[k] = cy_p[k-1];
      a_src[k] = a_p[k-1];
      b_src[k] = b_p[k-1];
      r_src[k] = r_p[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      s_c[k] = slice_add(a_src[k][k*SLICE +: SLICE], b_src[k][k*SLICE +: SLICE], c_src[k]);
      r_o[k] = r_src[k];
      r_o[k][k*SLICE +: SLICE] = s_c[k][SLICE-1:0];
    end
  end

  // Final stage: carry into the MSB recovered from the MSB sum bit.
  assign c_msb = a_src[L][WIDTH-1] ^ b_src[L][WIDTH-1] ^ s_c[L][SLICE-1];
  assign ov    = c_msb ^ s_c[L][SLICE];
`ifdef ADDSUB_SAT_EN
  assign q_n = sat_q(r_o[L], ov, c_msb);
`else
  assign q_n = r_o[L];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) vld_p[k] <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) vld_p[k] <= v_src[k];
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      for (int k = 0; k < L; k++) begin
        cy_p[k] <= s_c[k][SLICE];
        a_p[k]  <= a_src[k];
        b_p[k]  <= b_src[k];
        r_p[k]  <= r_o[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q    <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
      zero <= 1'b0;
    end else if (adv && v_src[L]) begin
      q    <= q_n;
      cout <= s_c[L][SLICE];
      ovf  <= ov;
      zero <= (q_n == '0);
    end
  end
endmodule

// File: tb/tb_addsub_pipe.sv
// tb_addsub_pipe: directed vectors for addsub_pipe (16/4 pipeline plus a 16/16 single-stage build).
module tb_addsub_pipe;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0, in_ready;
  logic [15:0] a = '0, b = '0;
  logic        sub = 1'b0;
  logic        out_valid, out_ready = 1'b1;
  logic [15:0] q;
  logic        cout, ovf, zero;

  logic        in_valid1 = 1'b0, in_ready1, out_valid1;
  logic [15:0] q1;
  logic        cout1, ovf1, zero1;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef ADDSUB_SAT_EN
  localparam logic [15:0] Q_POS = 16'h7FFF;
  localparam logic [15:0] Q_NEG = 16'h8000;
`else
  localparam logic [15:0] Q_POS = 16'h8000;
  localparam logic [15:0] Q_NEG = 16'h7FFF;
`endif

  logic [15:0] va [16] = '{16'h0001, 16'h7FFF, 16'hFFFF, 16'h8000, 16'h1234, 16'h0000, 16'hABCD, 16'h5555,
                           16'h7FFF, 16'h8000, 16'h00FF, 16'hF0F0, 16'h0F0F, 16'h4000, 16'hC000, 16'hFFFE};
  logic [15:0] vb [16] = '{16'h0001, 16'h7FFF, 16'hFFFF, 16'h8000, 16'h4321, 16'h0000, 16'h1234, 16'hAAAA,
                           16'h8000, 16'h7FFF, 16'h0001, 16'h0F0F, 16'hF0F1, 16'h4000, 16'hC000, 16'h0002};
  logic        vs [16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1,
                           1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  bit          rpat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  addsub_pipe #(.WIDTH(16), .SLICE(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .q(q), .cout(cout), .ovf(ovf), .zero(zero)
  );

  addsub_pipe #(.WIDTH(16), .SLICE(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid1), .out_ready(1'b1),
    .q(q1), .cout(cout1), .ovf(ovf1), .zero(zero1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference from integer arithmetic: {q, cout, ovf, zero}.
  function automatic logic [18:0] model(input logic [15:0] x, input logic [15:0] y, input logic s);
    int          sx, sy, sr;
    int unsigned ux, uy;
    logic        c, o;
    logic [15:0] r;
    ux = x; uy = y;
    sx = $signed(x); sy = $signed(y);
    if (s) begin
      sr = sx - sy; c = (ux >= uy); r = 16'(ux - uy);
    end else begin
      sr = sx + sy; c = ((ux + uy) > 65535); r = 16'(ux + uy);
    end
    o = (sr > 32767) || (sr < -32768);
`ifdef ADDSUB_SAT_EN
    if (o) r = (sr > 0) ? 16'h7FFF : 16'h8000;
`endif
    return {r, c, o, (r == 16'h0000)};
  endfunction

  task automatic run_one(input string tag, input logic [15:0] x, input logic [15:0] y,
                         input logic s, input logic [18:0] exp);
    int lat;
    @(negedge clk);
    a = x; b = y; sub = s; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, lat, 4);
    chk(tag, {q, cout, ovf, zero}, exp);
  endtask

  initial begin
    int          c, w, r, cnt;
    logic        stl, prev_stl;
    logic [18:0] prev_res;

    #3 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_fields", {q, cout, ovf, zero}, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid1", out_valid1, 0);
    rst_n = 1'b1;

    run_one("pos_ovf", 16'h7FFF, 16'h0001, 1'b0, {Q_POS, 1'b0, 1'b1, 1'b0});
    @(negedge clk);
    chk("vld_fall", out_valid, 0);
    run_one("wrap_zero", 16'hFFFF, 16'h0001, 1'b0, {16'h0000, 1'b1, 1'b0, 1'b1});
    run_one("sub_neg", 16'h0005, 16'h0007, 1'b1, {16'hFFFE, 1'b0, 1'b0, 1'b0});
    run_one("neg_ovf", 16'h8000, 16'h0001, 1'b1, {Q_NEG, 1'b1, 1'b1, 1'b0});
    run_one("sub_eq", 16'h1234, 16'h1234, 1'b1, {16'h0000, 1'b1, 1'b0, 1'b1});

    // Back-to-back beats under a stalling output.
    c = 0; w = 0; r = 0; prev_stl = 1'b0; prev_res = '0;
    while (r < 16 && c < 300) begin
      @(negedge clk);
      out_ready = rpat[c % 6];
      if (w < 16) begin
        in_valid = 1'b1; a = va[w]; b = vb[w]; sub = vs[w];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      stl = out_valid && !out_ready;
      chk("in_ready_stall", in_ready, !stl);
      if (prev_stl) chk("hold", {q, cout, ovf, zero}, prev_res);
      if (out_valid && out_ready) begin
        chk($sformatf("beat%0d", r), {q, cout, ovf, zero}, model(va[r], vb[r], vs[r]));
        r++;
      end
      prev_stl = stl;
      prev_res = {q, cout, ovf, zero};
      if (in_valid && in_ready) w++;
      c++;
    end
    chk("delivered", r, 16);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;

    // Reset with beats in flight.
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      a = 16'h1111 * 16'(i + 1); b = 16'h0101; sub = 1'b0; in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    #1;
    chk("pre_rst_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_fields", {q, cout, ovf, zero}, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    chk("stale_after_rst", cnt, 0);
    run_one("post_rst", 16'h0003, 16'h0004, 1'b0, {16'h0007, 1'b0, 1'b0, 1'b0});

    // Single-stage build.
    @(negedge clk);
    a = 16'h1234; b = 16'h4321; sub = 1'b0; in_valid1 = 1'b1;
    @(posedge clk);
    #1 in_valid1 = 1'b0;
    @(negedge clk);
    chk("s16_valid", out_valid1, 1);
    chk("s16_result", {q1, cout1, ovf1, zero1}, {16'h5555, 1'b0, 1'b0, 1'b0});

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
